uart_tx_module: RTL and testbench
=================================

// Module: uart_tx_module
// PURPOSE
//  UART 8N1 transmitter with a write-side FIFO. It is the upstream peer of uart_rx_module:
//  its tx_o line drives the receiver's rx_i. Bytes pushed by the host are buffered,
//  serialized LSB-first at the programmed baud, and sent back-to-back while the FIFO holds data.
// PARAMETERS
//  DATA_WIDTH       8   bits per frame payload
//  FIFO_DEPTH       16  TX FIFO entries
//  FIFO_ADDR_WIDTH  4   log2(FIFO_DEPTH)
//  BAUD_DIV         78  clk cycles per oversample tick (12 MHz / (9600*16))
//  OVERSAMPLE       16  ticks per bit, matching the RX oversampling
// PORTS
//  clk         in   1           system clock (12 MHz nominal)
//  rst         in   1           asynchronous reset, active-high
//  wr_en       in   1           push din_i into the FIFO (one byte per cycle)
//  din_i       in   DATA_WIDTH  byte to transmit
//  tx_o        out  1           serial line, idle high
//  tx_busy_o   out  1           high while a frame is on the line
//  fifo_full   out  1           FIFO holds FIFO_DEPTH entries
//  fifo_empty  out  1           FIFO holds 0 entries
// BEHAVIOUR
//  Reset (async, immediate): tx_o=1, tx_busy_o=0, fifo_empty=1, fifo_full=0.
//   Also clears FIFO pointers, baud and bit counters, and puts the FSM in IDLE.
//  Reset mid-frame aborts the frame. tx_o returns high at once. Buffered bytes are discarded.
//  FIFO write: accepted on a clk edge with wr_en=1 && fifo_full=0. When full, the write is
//   dropped silently and contents are unchanged.
//  Simultaneous push and internal pop (not full): both happen and the count is unchanged.
//  Pointers wrap modulo FIFO_DEPTH. Flags are registered and valid the cycle after the edge.
//  FSM states: IDLE -> START -> DATA -> STOP -> (START | IDLE). PARITY sits between DATA and
//   STOP only when enabled (see CONFIGURATION).
//   IDLE:  tx_o=1. If !fifo_empty: load shift reg from the FIFO head, pop, clear the baud and
//          tick counters, and go to START.
//   START: tx_o=0 for one bit time.
//   DATA:  tx_o=shift[0], shifting right once per bit, for DATA_WIDTH bits (bit counter 0..7).
//   STOP:  tx_o=1 for one bit time. At its end, a non-empty FIFO pops and goes straight to
//          START with no idle gap; otherwise the FSM goes to IDLE.
//  Bit time is exactly BAUD_DIV*OVERSAMPLE clk cycles (1248 at defaults).
//   The baud counter runs 0..BAUD_DIV-1 and the tick counter runs 0..OVERSAMPLE-1.
//  Latency: with an idle, empty FIFO, a wr_en at edge N gives fifo_empty=0 after N.
//   The FSM pops at N+1 and tx_o falls after N+2.
//  tx_busy_o=1 in every state except IDLE. tx_o is driven from a flop (glitch-free).
// CONFIGURATION
//  UART_TX_PARITY_EN defined: a PARITY state follows DATA and sends one even-parity bit
//   (XOR of the 8 data bits). The frame is then 11 bits.
//  UART_TX_PARITY_EN undefined: no PARITY state, plain 8N1, 10-bit frame.
// STRUCTURE
//  uart_pkg: tx_state_t enum (IDLE, START, DATA, PARITY, STOP); OVERSAMPLE constant;
//   BAUD_DIV default.
//  Sub-module uart_fifo (sync FIFO with wr_en/rd_en/full/empty), the same FIFO the RX path uses.
//  The baud tick counter and FSM live in this module.
// TESTING
//  1. Assert rst for 5 clks.
//     -> tx_o=1, tx_busy_o=0, fifo_empty=1, fifo_full=0 during and after reset.
//  2. Push 0xA5.
//     -> tx_o = 0,1,0,1,0,0,1,0,1,1, each bit 1248 clks.
//     -> Loopback into uart_rx_module gives dout_o=0xA5 and tx_busy_o falls after the stop bit.
//  3. Push 0x00, 0xFF, 0x55 on consecutive clks.
//     -> Three contiguous frames with no idle gap between them.
//     -> The RX FIFO reads back 0x00, 0xFF, 0x55.
//  4. Push 18 bytes 0x01..0x12 on consecutive clks.
//     -> 0x01 is popped at once and 0x02..0x11 fill the FIFO (fifo_full=1).
//     -> 0x12 is dropped, and 0x01..0x11 are transmitted in order.
//  5. Push 0x3C, then assert rst during data bit 3.
//     -> tx_o=1 in the same cycle, fifo_empty=1, and no further frames after rst is released.
//  6. With UART_TX_PARITY_EN, send 0xA5 and 0x07.
//     -> Parity bits are 0 and 1 respectively, and each frame is 11 bits (13728 clks).

Source files
------------

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types and constants (TX state encoding,
//               oversampling ratio, default baud divider).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam int OVERSAMPLE       = 16;
    localparam int BAUD_DIV_DEFAULT = 78;

endpackage

`default_nettype wire

// File: rtl/uart_fifo.sv
// ============================================================================
// Module      : uart_fifo
// Description : Synchronous FIFO with registered full/empty flags and a
//               show-ahead read port (head visible on o_dout).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_dout,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam logic [ADDR_WIDTH:0] c_depth = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   w_count_next;
    logic                  r_full;
    logic                  r_empty;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign w_do_wr = i_wr_en & ~r_full;
    assign w_do_rd = i_rd_en & ~r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_do_wr, w_do_rd})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage is not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_next;
            r_full  <= (w_count_next == c_depth);
            r_empty <= (w_count_next == '0);
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

`default_nettype wire

// File: rtl/uart_tx_module.sv
// ============================================================================
// Module      : uart_tx_module
// Description : UART transmitter (8N1, LSB first) fed by a write-side FIFO;
//               frames go out back-to-back while the FIFO holds data.
//               Define UART_TX_PARITY_EN to append an even-parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_module
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int FIFO_ADDR_WIDTH = 4,
    parameter int BAUD_DIV        = BAUD_DIV_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic                  tx_o,
    output logic                  tx_busy_o,
    output logic                  fifo_full,
    output logic                  fifo_empty
);

    localparam int c_baud_w = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int c_tick_w = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int c_bit_w  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [c_baud_w-1:0] c_baud_max = c_baud_w'(BAUD_DIV - 1);
    localparam logic [c_tick_w-1:0] c_tick_max = c_tick_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last = c_bit_w'(DATA_WIDTH - 1);

    tx_state_t             r_state;
    tx_state_t             w_state_next;
    logic [c_baud_w-1:0]   r_baud_cnt;
    logic [c_tick_w-1:0]   r_tick_cnt;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_fifo_dout;
    logic                  w_pop;
    logic                  w_bit_done;
    logic                  w_tx_next;
    logic                  r_tx;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    uart_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (FIFO_ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_wr_en (wr_en),
        .i_din   (din_i),
        .i_rd_en (w_pop),
        .o_dout  (w_fifo_dout),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    assign w_bit_done = (r_baud_cnt == c_baud_max) && (r_tick_cnt == c_tick_max);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (!fifo_empty) w_state_next = START;
            START:   if (w_bit_done)  w_state_next = DATA;
            DATA: begin
                if (w_bit_done && (r_bit_cnt == c_bit_last)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_next = PARITY;
`else
                    w_state_next = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY:  if (w_bit_done) w_state_next = STOP;
`endif
            STOP:    if (w_bit_done) w_state_next = fifo_empty ? IDLE : START;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_tx_next = 1'b1;
        w_pop     = 1'b0;
        case (r_state)
            IDLE:  w_pop = !fifo_empty;
            START: w_tx_next = 1'b0;
            DATA:  w_tx_next = r_shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY: w_tx_next = r_parity;
`endif
            STOP:  w_pop = w_bit_done && !fifo_empty;
            default: w_tx_next = 1'b1;
        endcase
    end

    // A pop restarts bit timing so the next START is a full bit long.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else if (w_pop) begin
            r_baud_cnt <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= w_fifo_dout;
`ifdef UART_TX_PARITY_EN
            r_parity   <= ^w_fifo_dout;
`endif
        end else if (r_state == IDLE) begin
            r_baud_cnt <= '0;
            r_tick_cnt <= '0;
        end else begin
            if (r_baud_cnt == c_baud_max) begin
                r_baud_cnt <= '0;
                r_tick_cnt <= (r_tick_cnt == c_tick_max) ? '0 : r_tick_cnt + 1'b1;
            end else begin
                r_baud_cnt <= r_baud_cnt + 1'b1;
            end
            if (w_bit_done && (r_state == DATA)) begin
                r_shift   <= r_shift >> 1;
                r_bit_cnt <= (r_bit_cnt == c_bit_last) ? '0 : r_bit_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx <= 1'b1;
        end else begin
            r_tx <= w_tx_next;
        end
    end

    assign tx_o      = r_tx;
    assign tx_busy_o = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_module.sv
// ============================================================================
// Module      : tb_uart_tx_module
// Description : Directed self-checking bench for uart_tx_module (small baud
//               divider); parity scenario active with UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_module;

    localparam int BAUD_DIV = 3;
    localparam int BIT      = BAUD_DIV * 16;
    localparam int LIMIT    = 20000;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] din;
    wire        tx;
    wire        busy;
    wire        full;
    wire        empty;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_module #(
        .DATA_WIDTH      (8),
        .FIFO_DEPTH      (16),
        .FIFO_ADDR_WIDTH (4),
        .BAUD_DIV        (BAUD_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .din_i      (din),
        .tx_o       (tx),
        .tx_busy_o  (busy),
        .fifo_full  (full),
        .fifo_empty (empty)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [7:0] b);
        din   = b;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Waits for a start bit, then samples each bit at its centre.
    task automatic recv_frame(output logic [7:0] data, output logic par, output int wait_n,
                              output logic start_ok, output logic stop_ok, output logic timed_out);
        data = 8'h00; par = 1'b0; start_ok = 1'b0; stop_ok = 1'b0; timed_out = 1'b0;
        wait_n = 0;
        while (tx !== 1'b0 && wait_n < LIMIT) begin
            @(negedge clk);
            wait_n++;
        end
        if (tx !== 1'b0) begin
            timed_out = 1'b1;
            return;
        end
        repeat (BIT / 2) @(negedge clk);
        start_ok = (tx === 1'b0);
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            data[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (BIT) @(negedge clk);
        par = tx;
`endif
        repeat (BIT) @(negedge clk);
        stop_ok = (tx === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; din = 8'h00;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({tx, busy, empty, full} !== 4'b1010) begin
            n_err++;
            $display("FAIL reset_during: {tx,busy,empty,full} got %b expected 1010", {tx, busy, empty, full});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({tx, busy, empty, full} !== 4'b1010) begin
            n_err++;
            $display("FAIL reset_after: {tx,busy,empty,full} got %b expected 1010", {tx, busy, empty, full});
        end
    endtask

    task automatic test_single();
`ifdef UART_TX_PARITY_EN
        logic exp_bits [NBITS] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
        logic exp_bits [NBITS] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif
        din = 8'hA5; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        n_cmp++;
        if ({empty, busy, tx} !== 3'b001) begin
            n_err++;
            $display("FAIL latency_write: {empty,busy,tx} got %b expected 001", {empty, busy, tx});
        end
        @(negedge clk);
        n_cmp++;
        if ({empty, busy, tx} !== 3'b111) begin
            n_err++;
            $display("FAIL latency_pop: {empty,busy,tx} got %b expected 111", {empty, busy, tx});
        end
        @(negedge clk);
        n_cmp++;
        if (tx !== 1'b0) begin
            n_err++;
            $display("FAIL latency_start: tx got %b expected 0", tx);
        end
        for (int b = 0; b < NBITS; b++) begin
            int bad = 0;
            for (int c = 0; c < BIT; c++) begin
                if (tx !== exp_bits[b]) bad++;
                if (b == NBITS - 1 && c == BIT - 2) begin
                    n_cmp++;
                    if (busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL busy_in_stop: got %b expected 1", busy);
                    end
                end
                if (b == NBITS - 1 && c == BIT - 1) begin
                    n_cmp++;
                    if (busy !== 1'b0) begin
                        n_err++;
                        $display("FAIL busy_after_stop: got %b expected 0", busy);
                    end
                end
                @(negedge clk);
            end
            n_cmp++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL frame_A5_bit%0d: %0d of %0d cycles wrong, expected level %b", b, bad, BIT, exp_bits[b]);
            end
        end
        n_cmp++;
        if ({tx, busy, empty} !== 3'b101) begin
            n_err++;
            $display("FAIL single_idle: {tx,busy,empty} got %b expected 101", {tx, busy, empty});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp3 [3] = '{8'h00, 8'hFF, 8'h55};
        fork
            begin
                push(8'h00);
                push(8'hFF);
                push(8'h55);
            end
            begin
                logic [7:0] d;
                logic p, so, eo, to;
                int wn;
                for (int f = 0; f < 3; f++) begin
                    recv_frame(d, p, wn, so, eo, to);
                    n_cmp++;
                    if (to || d !== exp3[f] || !so || !eo) begin
                        n_err++;
                        $display("FAIL b2b_frame%0d: data %h start_ok %b stop_ok %b timeout %b expected data %h", f, d, so, eo, to, exp3[f]);
                    end
                    if (f > 0) begin
                        n_cmp++;
                        if (wn != BIT / 2) begin
                            n_err++;
                            $display("FAIL b2b_gap%0d: stop-centre to start %0d cycles expected %0d", f, wn, BIT / 2);
                        end
                    end
                    if (to) break;
                end
            end
        join
        repeat (BIT) @(negedge clk);
        n_cmp++;
        if ({busy, empty} !== 2'b01) begin
            n_err++;
            $display("FAIL b2b_idle: {busy,empty} got %b expected 01", {busy, empty});
        end
    endtask

    task automatic test_fill_drop();
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    din   = 8'(i + 1);
                    wr_en = 1'b1;
                    @(negedge clk);
                    if (i == 15) begin
                        n_cmp++;
                        if (full !== 1'b0) begin
                            n_err++;
                            $display("FAIL fill_15: full got %b expected 0", full);
                        end
                    end
                    if (i >= 16) begin
                        n_cmp++;
                        if (full !== 1'b1) begin
                            n_err++;
                            $display("FAIL fill_%0d: full got %b expected 1", i, full);
                        end
                    end
                end
                wr_en = 1'b0;
            end
            begin
                logic [7:0] d;
                logic p, so, eo, to;
                int wn;
                for (int f = 0; f < 17; f++) begin
                    recv_frame(d, p, wn, so, eo, to);
                    n_cmp++;
                    if (to || d !== 8'(f + 1) || !so || !eo) begin
                        n_err++;
                        $display("FAIL fill_frame%0d: data %h start_ok %b stop_ok %b timeout %b expected data %h", f, d, so, eo, to, 8'(f + 1));
                    end
                    if (to) break;
                end
            end
        join
        repeat (2 * BIT) @(negedge clk);
        n_cmp++;
        if ({tx, busy, empty} !== 3'b101) begin
            n_err++;
            $display("FAIL fill_no_extra: {tx,busy,empty} got %b expected 101", {tx, busy, empty});
        end
    endtask

    task automatic test_reset_midframe();
        int wn = 0;
        int bad = 0;
        push(8'h3C);
        push(8'h99);
        while (tx !== 1'b0 && wn < LIMIT) begin
            @(negedge clk);
            wn++;
        end
        repeat (4 * BIT + BIT / 2) @(negedge clk);
        n_cmp++;
        if (tx !== 1'b1) begin
            n_err++;
            $display("FAIL midframe_bit3: tx got %b expected 1", tx);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({tx, busy, empty, full} !== 4'b1010) begin
            n_err++;
            $display("FAIL midframe_reset: {tx,busy,empty,full} got %b expected 1010", {tx, busy, empty, full});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3 * NBITS * BIT; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL midframe_quiet: %0d active cycles after reset expected 0", bad);
        end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] expd [2] = '{8'hA5, 8'h07};
        logic       expp [2] = '{1'b0, 1'b1};
        fork
            begin
                push(8'hA5);
                push(8'h07);
            end
            begin
                logic [7:0] d;
                logic p, so, eo, to;
                int wn;
                for (int f = 0; f < 2; f++) begin
                    recv_frame(d, p, wn, so, eo, to);
                    n_cmp++;
                    if (to || d !== expd[f] || p !== expp[f] || !so || !eo) begin
                        n_err++;
                        $display("FAIL parity_frame%0d: data %h par %b stop_ok %b timeout %b expected data %h par %b", f, d, p, eo, to, expd[f], expp[f]);
                    end
                    if (f == 1) begin
                        n_cmp++;
                        if (wn != BIT / 2) begin
                            n_err++;
                            $display("FAIL parity_gap: %0d cycles expected %0d", wn, BIT / 2);
                        end
                    end
                    if (to) break;
                end
            end
        join
        repeat (BIT) @(negedge clk);
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        wr_en = 1'b0;
        din   = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_fill_drop();
        test_reset_midframe();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
